// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: opcodes,
// FSM state codes, datapath select codes and ALU control codes.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC_R = 4'd6;
  localparam state_t S_EXEC_I = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_JAL    = 4'd9;
  localparam state_t S_BRANCH = 4'd10;
  localparam state_t S_LUI    = 4'd11;
  localparam state_t S_TRAP   = 4'd12;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // True when the decoded instruction has no implementation in this sequencer.
  function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD, OP_STORE, OP_JAL, OP_LUI: return 1'b0;
      OP_R, OP_I:                        return !alu_f3_ok(f3);
      OP_BRANCH:                         return f3[2:1] != 2'b00;
      default:                           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU control decode: fixed add/sub requests or funct-field decode for R/I ops.
module alu_dec
  import rv32_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32I control sequencer (Moore FSM + ALU decode).
// Optional ILLEGAL_TRAP_EN: unsupported instructions lock into a trap state.
module mc_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       adr_src_o,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_ctrl_o,
  output logic [2:0] imm_src_o,
  output logic       instr_done_o,
  output logic       mem_err_o,
  output logic       illegal_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            mem_state;
  logic            timeout;
  logic [1:0]      alu_op;
  logic            is_rtype;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  always_comb begin
    timeout = 1'b0;
    if (MEM_TIMEOUT > 0)
      timeout = mem_state && !mem_ready_i && (cnt == CW'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready_i) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_FETCH;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (is_illegal(opcode_i, funct3_i)) state_next = S_TRAP;
`endif
      end
      S_MEMADR: state_next = (opcode_i == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready_i) state_next = S_MEMWB;
                else if (timeout) state_next = S_FETCH;
      S_MEMWR:  if (mem_ready_i || timeout) state_next = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL: state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_next;
  end

  // A timeout re-enters FETCH without a state change, so it clears the count explicitly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (state_next != state || timeout || !mem_state)
      cnt <= '0;
    else if (!mem_ready_i && MEM_TIMEOUT > 0)
      cnt <= cnt + CW'(1);
  end

  // Outputs are gated by rst_i so an asserted reset silences them immediately.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = '0;
    alu_src_a_o  = '0;
    alu_src_b_o  = '0;
    imm_src_o    = '0;
    instr_done_o = 1'b0;
    mem_err_o    = 1'b0;
    illegal_o    = 1'b0;
    alu_op       = ALUOP_ADD;
    is_rtype     = 1'b0;
    if (!rst_i) begin
      mem_err_o = timeout;
      case (state)
        S_FETCH: begin
          mem_req_o    = 1'b1;
          alu_src_a_o  = SRCA_PC;
          alu_src_b_o  = SRCB_FOUR;
          result_src_o = RES_ALURES;
          ir_write_o   = mem_ready_i;
          pc_write_o   = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_a_o = SRCA_OLDPC;
          alu_src_b_o = SRCB_IMM;
          imm_src_o   = (opcode_i == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_IMM;
          imm_src_o   = (opcode_i == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMRD: begin
          mem_req_o = 1'b1;
          adr_src_o = 1'b1;
        end
        S_MEMWB: begin
          result_src_o = RES_RDATA;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEMWR: begin
          mem_req_o    = 1'b1;
          mem_write_o  = 1'b1;
          adr_src_o    = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_EXEC_R: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_RS2;
          alu_op      = ALUOP_FUNCT;
          is_rtype    = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_IMM;
          imm_src_o   = IMM_I;
          alu_op      = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          result_src_o = RES_ALUOUT;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_JAL: begin
          alu_src_a_o  = SRCA_OLDPC;
          alu_src_b_o  = SRCB_FOUR;
          result_src_o = RES_ALUOUT;
          pc_write_o   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o  = SRCA_RS1;
          alu_src_b_o  = SRCB_RS2;
          alu_op       = ALUOP_SUB;
          result_src_o = RES_ALUOUT;
          pc_write_o   = (funct3_i[2:1] == 2'b00) ? (zero_i ^ funct3_i[0]) : 1'b0;
          instr_done_o = 1'b1;
        end
        S_LUI: begin
          imm_src_o    = IMM_U;
          result_src_o = RES_IMM;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          illegal_o = 1'b1;
`endif
          mem_err_o = 1'b0;
        end
        default: ;
      endcase
    end
  end

  alu_dec u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (funct3_i),
    .funct7b5 (funct7b5_i),
    .is_rtype (is_rtype),
    .alu_ctrl (alu_ctrl_o)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected output traces
// built from the instruction-level rules, with randomized memory latency.
module tb_mc_ctrl;

  localparam int TO = 4;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write, ir_write, adr_src, mem_req, mem_write, reg_write;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] alu, imm;
    logic       done, err, illegal;
  } out_t;

  typedef struct packed {
    logic       ready;
    logic [3:0] ph;
    out_t       exp;
  } step_t;

  logic clk, rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7b5, zero, mem_ready;
  logic pc_write_o, ir_write_o, adr_src_o, mem_req_o, mem_write_o, reg_write_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o;
  logic [2:0] alu_ctrl_o, imm_src_o;
  logic instr_done_o, mem_err_o, illegal_o;
  out_t obs;

  int tests = 0;
  int fails = 0;
  step_t q[$];

  mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3),
    .funct7b5_i(funct7b5), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .adr_src_o(adr_src_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_ctrl_o(alu_ctrl_o), .imm_src_o(imm_src_o), .instr_done_o(instr_done_o),
    .mem_err_o(mem_err_o), .illegal_o(illegal_o)
  );

  assign obs = {pc_write_o, ir_write_o, adr_src_o, mem_req_o, mem_write_o, reg_write_o,
                result_src_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o, imm_src_o,
                instr_done_o, mem_err_o, illegal_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input out_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t o_fetch();
    out_t o = '0;
    o.mem_req = 1'b1; o.src_b = 2'b10; o.result_src = 2'b10;
    return o;
  endfunction

  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic f7, input logic r);
    case (f3)
      3'b000:  return (r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic f3_ok(input logic [2:0] f3);
    return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
  endfunction

  task automatic push(input logic r, input logic [3:0] ph, input out_t e);
    step_t s;
    s.ready = r; s.ph = ph; s.exp = e;
    q.push_back(s);
  endtask

  task automatic waits(input out_t base, input int n, input logic [3:0] ph);
    for (int i = 0; i < n; i++) push(1'b0, ph, base);
  endtask

  task automatic timeout_phase(input out_t base, input logic [3:0] ph);
    out_t e = base;
    waits(base, TO - 1, ph);
    e.err = 1'b1;
    push(1'b0, ph, e);
  endtask

  task automatic trap_steps(output bit trapped);
    out_t e = '0;
    e.illegal = 1'b1;
    repeat (3) push(rb(), 4'd9, e);
    trapped = 1'b1;
  endtask

  task automatic aluwb();
    out_t e = '0;
    e.reg_write = 1'b1; e.done = 1'b1;
    push(rb(), 4'd8, e);
  endtask

  // fw/mw: wait cycles before ready; TO means a timeout; negative picks randomly.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic zr, input int fw, input int mw, output bit trapped);
    out_t e;
    int w;
    trapped = 1'b0;
    w = (fw < 0) ? int'($urandom_range(0, TO)) : fw;
    if (w == TO) begin
      timeout_phase(o_fetch(), 4'd0);
      w = int'($urandom_range(0, TO - 1));
    end
    waits(o_fetch(), w, 4'd0);
    e = o_fetch(); e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b1, 4'd0, e);
    e = '0; e.src_a = 2'b01; e.src_b = 2'b01;
    e.imm = (op == 7'b1101111) ? 3'b100 : 3'b010;
    push(rb(), 4'd1, e);
    case (op)
      7'b0000011, 7'b0100011: begin
        e = '0; e.src_a = 2'b10; e.src_b = 2'b01;
        e.imm = (op == 7'b0100011) ? 3'b001 : 3'b000;
        push(rb(), 4'd2, e);
        e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = (op == 7'b0100011);
        w = (mw < 0) ? int'($urandom_range(0, TO)) : mw;
        if (w == TO) timeout_phase(e, 4'd3);
        else begin
          waits(e, w, 4'd3);
          if (op == 7'b0100011) begin
            e.done = 1'b1;
            push(1'b1, 4'd3, e);
          end else begin
            push(1'b1, 4'd3, e);
            e = '0; e.result_src = 2'b01; e.reg_write = 1'b1; e.done = 1'b1;
            push(rb(), 4'd4, e);
          end
        end
      end
      7'b0110011, 7'b0010011: begin
        if (TRAP_EN && !f3_ok(f3)) trap_steps(trapped);
        else begin
          e = '0; e.src_a = 2'b10;
          e.src_b = (op == 7'b0110011) ? 2'b00 : 2'b01;
          e.alu = alu_exp(f3, f7, op == 7'b0110011);
          push(rb(), 4'd5, e);
          aluwb();
        end
      end
      7'b1101111: begin
        e = '0; e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1;
        push(rb(), 4'd6, e);
        aluwb();
      end
      7'b1100011: begin
        if (TRAP_EN && f3 > 3'd1) trap_steps(trapped);
        else begin
          e = '0; e.src_a = 2'b10; e.alu = 3'b001; e.done = 1'b1;
          e.pc_write = (f3 == 3'd0) ? zr : (f3 == 3'd1) ? !zr : 1'b0;
          push(rb(), 4'd7, e);
        end
      end
      7'b0110111: begin
        e = '0; e.imm = 3'b011; e.result_src = 2'b11; e.reg_write = 1'b1; e.done = 1'b1;
        push(rb(), 4'd10, e);
      end
      default: if (TRAP_EN) trap_steps(trapped);
    endcase
  endtask

  task automatic run_q(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic zr);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      opcode = op; funct3 = f3; funct7b5 = f7; zero = zr;
      mem_ready = s.ready;
      #1 check($sformatf("phase%0d op=%b f3=%0d", s.ph, op, f3), s.exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1 check("reset_assert", '0);
    @(posedge clk);
    #1 check("reset_hold", '0);
    rst = 1'b0;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic zr, input int fw, input int mw);
    bit trapped;
    build(op, f3, f7, zr, fw, mw, trapped);
    run_q(op, f3, f7, zr);
    if (trapped) do_reset();
  endtask

  initial begin
    logic [6:0] ops [8];
    out_t e;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1101111; ops[5] = 7'b1100011; ops[6] = 7'b0110111; ops[7] = 7'b1110011;

    rst = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    #1 check("reset_idle", '0);
    mem_ready = 1'b1;
    #1 check("reset_ready_high", '0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3, 0);
    instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1);
    instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
    instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
    instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1, 0);
    instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
    instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
    instr(7'b1101111, 3'd0, 1'b0, 1'b0, 2, 0);
    instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
    instr(7'b0000011, 3'd2, 1'b0, 1'b0, TO, TO);
    instr(7'b0000011, 3'd2, 1'b0, 1'b0, TO - 1, TO - 1);
    instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, TO);
    instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0);
    instr(7'b0110011, 3'd3, 1'b0, 1'b0, 0, 0);

    // Reset asserted while a load waits in its memory-read phase.
    e = o_fetch(); e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b1, 4'd0, e);
    e = '0; e.src_a = 2'b01; e.src_b = 2'b01; e.imm = 3'b010;
    push(1'b0, 4'd1, e);
    e = '0; e.src_a = 2'b10; e.src_b = 2'b01;
    push(1'b0, 4'd2, e);
    e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1;
    push(1'b0, 4'd3, e);
    run_q(7'b0000011, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    #1 check("memrd_before_reset", e);
    rst = 1'b1;
    #1 check("memrd_async_reset", '0);
    @(posedge clk);
    #1 rst = 1'b0;
    instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++)
      instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), rb(), rb(), -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
